// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment capture block: segment pattern codes,
// the sampled segment type and the stability FSM state encoding.
package seg7_pkg;

  // Active-high segment vector: [7]=dp, [6:0]=g..a
  typedef logic [7:0] seg_t;

  localparam seg_t SEG_0     = 8'h3F;
  localparam seg_t SEG_1     = 8'h06;
  localparam seg_t SEG_2     = 8'h5B;
  localparam seg_t SEG_3     = 8'h4F;
  localparam seg_t SEG_4     = 8'h66;
  localparam seg_t SEG_5     = 8'h6D;
  localparam seg_t SEG_6     = 8'h7D;
  localparam seg_t SEG_7     = 8'h07;
  localparam seg_t SEG_8     = 8'h7F;
  localparam seg_t SEG_9     = 8'h6F;
  localparam seg_t SEG_A     = 8'h77;
  localparam seg_t SEG_B     = 8'h7C;
  localparam seg_t SEG_C     = 8'h39;
  localparam seg_t SEG_D     = 8'h5E;
  localparam seg_t SEG_E     = 8'h79;
  localparam seg_t SEG_F     = 8'h71;
  localparam seg_t SEG_BLANK = 8'h00;

  typedef enum logic {
    StCount,
    StHeld
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of a 7-segment pattern (active-high, dp excluded) back
// to a hex nibble. Blank and unrecognised patterns both yield nibble 0.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       invalid
);

  // Pattern lookup; anything not in the table is flagged invalid
  always_comb begin
    nibble  = 4'h0;
    blank   = 1'b0;
    invalid = 1'b0;
    case ({1'b0, pattern})
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: blank  = 1'b1;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Receive side of the multiplexed 7-segment bus. Synchronises segment and
// strobe lines, accepts a digit once it has been stable long enough, and
// assembles digits into a frame. Optional decimal-point capture is built when
// SEG7_DP_CAPTURE_EN is defined.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                seg_n,
  input  logic [NUM_DIGITS-1:0]     dig_n,
  output logic [4*NUM_DIGITS-1:0]   value,
  output logic [NUM_DIGITS-1:0]     blank_mask,
  output logic                      frame_valid,
  output logic                      frame_err,
  output logic                      timeout
`ifdef SEG7_DP_CAPTURE_EN
  ,
  output logic [NUM_DIGITS-1:0]     dp
`endif
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntArm  = CntW'(STABLE_CYCLES - 2);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  // Synchroniser stages hold inverted (active-high) values, so reset = idle bus
  seg_t                  seg_s1_q, seg_s2_q;
  logic [NUM_DIGITS-1:0] dig_s1_q, dig_s2_q;
  logic [NUM_DIGITS+7:0] prev_q;

  state_e                state_q, state_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  changed, one_hot, capture;

  logic [3:0]            dec_nibble;
  logic                  dec_blank, dec_invalid;

  logic [4*NUM_DIGITS-1:0] nib_q, nib_d, value_q, value_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d, inv_q, inv_d, mask_q, mask_d;
  logic [NUM_DIGITS-1:0]   blank_mask_q, blank_mask_d;
  logic                    frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;
  logic                    timeout_q, timeout_d;
  logic [TmoW-1:0]         tcnt_q, tcnt_d;
`ifdef SEG7_DP_CAPTURE_EN
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d, dp_q, dp_d;
`endif

  // Two-flop synchroniser plus one-cycle-old copy for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      dig_s1_q <= '0;
      dig_s2_q <= '0;
      prev_q   <= '0;
    end else begin
      seg_s1_q <= ~seg_n;
      seg_s2_q <= seg_s1_q;
      dig_s1_q <= ~dig_n;
      dig_s2_q <= dig_s1_q;
      prev_q   <= {seg_s2_q, dig_s2_q};
    end
  end

  assign changed = ({seg_s2_q, dig_s2_q} != prev_q);
  assign one_hot = (dig_s2_q != '0) &&
                   ((dig_s2_q & (dig_s2_q - NUM_DIGITS'(1))) == '0);

  // FSM state and stability counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StCount;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state: count stable one-hot samples, hold off after a capture
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      StCount: begin
        if (changed || !one_hot) begin
          count_d = '0;
        end else if (count_q != CntLast) begin
          count_d = count_q + CntW'(1);
        end
        if (capture) state_d = StHeld;
      end
      StHeld: begin
        if (changed) begin
          state_d = StCount;
          count_d = '0;
        end
      end
    endcase
  end

  // FSM output: capture on the sample that brings the count to its last value
  always_comb begin
    capture = (state_q == StCount) && !changed && one_hot && (count_q == CntArm);
  end

  seg7_pattern_decode u_decode (
    .pattern (seg_s2_q[6:0]),
    .nibble  (dec_nibble),
    .blank   (dec_blank),
    .invalid (dec_invalid)
  );

  // Shadow/mask update, frame completion and partial-frame timeout
  always_comb begin
    mask_d        = mask_q;
    nib_d         = nib_q;
    blank_d       = blank_q;
    inv_d         = inv_q;
    tcnt_d        = tcnt_q;
    value_d       = value_q;
    blank_mask_d  = blank_mask_q;
    frame_err_d   = frame_err_q;
    frame_valid_d = 1'b0;
    timeout_d     = 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
    dp_sh_d       = dp_sh_q;
    dp_d          = dp_q;
`endif
    if (capture) begin
      tcnt_d = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig_s2_q[i]) begin
          nib_d[4*i +: 4] = dec_nibble;
          blank_d[i]      = dec_blank;
          inv_d[i]        = dec_invalid;
          mask_d[i]       = 1'b1;
`ifdef SEG7_DP_CAPTURE_EN
          dp_sh_d[i]      = seg_s2_q[7];
`endif
        end
      end
      if (&mask_d) begin
        frame_valid_d = 1'b1;
        value_d       = nib_d;
        blank_mask_d  = blank_d;
        frame_err_d   = |inv_d;
        mask_d        = '0;
        inv_d         = '0;
`ifdef SEG7_DP_CAPTURE_EN
        dp_d          = dp_sh_d;
`endif
      end
    end else if (mask_q != '0) begin
      // Capture has priority, so the timeout only fires on an idle cycle
      if (tcnt_q == TmoLast) begin
        timeout_d = 1'b1;
        tcnt_d    = '0;
        mask_d    = '0;
        nib_d     = '0;
        blank_d   = '0;
        inv_d     = '0;
`ifdef SEG7_DP_CAPTURE_EN
        dp_sh_d   = '0;
`endif
      end else begin
        tcnt_d = tcnt_q + TmoW'(1);
      end
    end else begin
      tcnt_d = '0;
    end
  end

  // Shadow, mask, timeout counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q        <= '0;
      nib_q         <= '0;
      blank_q       <= '0;
      inv_q         <= '0;
      tcnt_q        <= '0;
      value_q       <= '0;
      blank_mask_q  <= '0;
      frame_err_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      mask_q        <= mask_d;
      nib_q         <= nib_d;
      blank_q       <= blank_d;
      inv_q         <= inv_d;
      tcnt_q        <= tcnt_d;
      value_q       <= value_d;
      blank_mask_q  <= blank_mask_d;
      frame_err_q   <= frame_err_d;
      frame_valid_q <= frame_valid_d;
      timeout_q     <= timeout_d;
    end
  end

`ifdef SEG7_DP_CAPTURE_EN
  // Decimal-point shadow and frame registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_sh_q <= '0;
      dp_q    <= '0;
    end else begin
      dp_sh_q <= dp_sh_d;
      dp_q    <= dp_d;
    end
  end

  assign dp = dp_q;
`endif

  assign value       = value_q;
  assign blank_mask  = blank_mask_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: table of full-frame scans plus hand-written
// sequences for reset, glitch, multi-strobe and timeout corner cases.
module tb_seg7_capture;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 16;
  localparam int unsigned TC = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    seg_n;
  logic [ND-1:0] dig_n;
  logic [4*ND-1:0] value;
  logic [ND-1:0] blank_mask;
  logic          frame_valid;
  logic          frame_err;
  logic          timeout;
`ifdef SEG7_DP_CAPTURE_EN
  logic [ND-1:0] dp;
`endif

  always #5 clk = ~clk;

  seg7_capture #(
    .NUM_DIGITS     (ND),
    .STABLE_CYCLES  (SC),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dig_n       (dig_n),
    .value       (value),
    .blank_mask  (blank_mask),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .timeout     (timeout)
`ifdef SEG7_DP_CAPTURE_EN
    ,
    .dp          (dp)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int fv_cyc = 0;
  int to_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt <= fv_cnt + 1;
      fv_cyc <= cyc;
    end
    if (timeout) to_cnt <= to_cnt + 1;
  end

  typedef struct {
    logic [7:0]  p0, p1, p2, p3;
    logic [15:0] exp_value;
    logic [3:0]  exp_blank;
    logic        exp_err;
    logic [3:0]  exp_dp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called and returns at posedge+1; drives a digit for n sampling edges
  task automatic show(input int idx, input logic [7:0] pat, input int n);
    logic [ND-1:0] oh;
    oh    = 4'b0001 << idx;
    seg_n = ~pat;
    dig_n = ~oh;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    seg_n = 8'hFF;
    dig_n = '1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int f0, t0, t3;
    logic [15:0] held;

    vecs[0] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 16'h4321, 4'b0000, 1'b0, 4'b0000};
    vecs[1] = '{8'h3F, 8'h77, 8'h7C, 8'h39, 16'hCBA0, 4'b0000, 1'b0, 4'b0000};
    vecs[2] = '{8'h5E, 8'h79, 8'h71, 8'h6F, 16'h9FED, 4'b0000, 1'b0, 4'b0000};
    vecs[3] = '{8'h7F, 8'h49, 8'h07, 8'h00, 16'h0708, 4'b1000, 1'b1, 4'b0000};
    vecs[4] = '{8'h6D, 8'h7D, 8'hCF, 8'h66, 16'h4365, 4'b0000, 1'b0, 4'b0100};

    rst_n = 1'b0;
    seg_n = 8'hFF;
    dig_n = '1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_value", 32'(value), 32'h0);
    check("reset_blank", 32'(blank_mask), 32'h0);
    check("reset_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    idle(3);
    check("idle_fv", 32'(frame_valid), 32'h0);
    check("idle_timeout", 32'(timeout), 32'h0);

    // Full-frame scans
    for (int v = 0; v < 5; v++) begin
      f0 = fv_cnt;
      show(0, vecs[v].p0, 40);
      show(1, vecs[v].p1, 40);
      show(2, vecs[v].p2, 40);
      t3 = cyc;
      show(3, vecs[v].p3, 40);
      idle(5);
      check($sformatf("vec%0d_fv_count", v), 32'(fv_cnt - f0), 32'd1);
      check($sformatf("vec%0d_latency", v), 32'(fv_cyc - t3), 32'(SC + 2));
      check($sformatf("vec%0d_value", v), 32'(value), 32'(vecs[v].exp_value));
      check($sformatf("vec%0d_blank", v), 32'(blank_mask), 32'(vecs[v].exp_blank));
      check($sformatf("vec%0d_err", v), 32'(frame_err), 32'(vecs[v].exp_err));
`ifdef SEG7_DP_CAPTURE_EN
      check($sformatf("vec%0d_dp", v), 32'(dp), 32'(vecs[v].exp_dp));
`endif
    end

    // Reset mid-frame: partial frame is lost
    f0 = fv_cnt;
    t0 = to_cnt;
    show(0, 8'h06, 40);
    show(1, 8'h5B, 40);
    idle(2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_value", 32'(value), 32'h0);
    check("midrst_err", 32'(frame_err), 32'h0);
    show(2, 8'h4F, 40);
    show(3, 8'h66, 40);
    idle(5);
    check("midrst_no_frame", 32'(fv_cnt - f0), 32'd0);
    idle(TC + 40);
    check("midrst_partial_timeout", 32'(to_cnt - t0), 32'd1);

    // Glitch: one sample short of stable -> no capture, so no timeout later
    t0 = to_cnt;
    show(2, 8'h5B, SC - 1);
    idle(TC + 40);
    check("glitch_no_capture", 32'(to_cnt - t0), 32'd0);
    // Exactly STABLE_CYCLES samples -> captured, partial frame then times out
    show(2, 8'h5B, SC);
    idle(TC + 40);
    check("stable_exact_capture", 32'(to_cnt - t0), 32'd1);

    // Two strobes active -> no capture
    t0 = to_cnt;
    f0 = fv_cnt;
    seg_n = ~8'h7F;
    dig_n = 4'b1100;
    repeat (100) @(posedge clk);
    #1;
    idle(TC + 40);
    check("twostrobe_no_capture", 32'(to_cnt - t0), 32'd0);
    show(0, 8'h7F, 40);
    show(1, 8'h06, 40);
    show(2, 8'h5B, 40);
    show(3, 8'h4F, 40);
    idle(5);
    check("twostrobe_then_frame", 32'(fv_cnt - f0), 32'd1);
    check("digit0_eight", 32'(value[3:0]), 32'h8);
    check("twostrobe_value", 32'(value), 32'h3218);

    // Timeout on a partial frame: pulse once, outputs held
    held = value;
    t0 = to_cnt;
    f0 = fv_cnt;
    show(0, 8'h06, 40);
    show(1, 8'h5B, 40);
    idle(TC + 40);
    check("timeout_pulse", 32'(to_cnt - t0), 32'd1);
    check("timeout_no_frame", 32'(fv_cnt - f0), 32'd0);
    check("timeout_value_held", 32'(value), 32'(held));
    show(0, 8'h06, 40);
    show(1, 8'h5B, 40);
    show(2, 8'hCF, 40);
    show(3, 8'h66, 40);
    idle(5);
    check("after_timeout_frame", 32'(fv_cnt - f0), 32'd1);
    check("after_timeout_value", 32'(value), 32'h4321);
    check("after_timeout_err", 32'(frame_err), 32'h0);
`ifdef SEG7_DP_CAPTURE_EN
    check("after_timeout_dp", 32'(dp), 32'h4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
